// File: rtl/spine_arb_pkg.sv
// Shared types and sizing helpers for the spine router output arbiter.
// The optional watchdog is enabled by defining SPINE_ARB_WATCHDOG_EN.
package spine_arb_pkg;

  localparam int NUM_PORTS_DEF = 11;

  // One state bit: IDLE arbitrates, LOCK holds a grant for a whole packet.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Width of a port index / round-robin pointer for n ports.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PTR_W = ptr_w(NUM_PORTS_DEF);

endpackage

// File: rtl/spine_output_arbiter_if.sv
// Bundle of request-side and output-FIFO-side signals for one output port.
// master = arbiter side, slave = the surrounding input ports / output FIFO.
interface spine_output_arbiter_if
  import spine_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int DWIDTH    = 16
);

  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        req_last;
  logic [NUM_PORTS*DWIDTH-1:0] in_data;
  logic                        out_fifo_full;
  logic [NUM_PORTS-1:0]        grant;
  logic                        xfer;
  logic [DWIDTH-1:0]           out_data;
  logic                        out_valid;
  logic                        busy;
  logic                        wd_err;

  modport master (
    input  req, req_last, in_data, out_fifo_full,
    output grant, xfer, out_data, out_valid, busy, wd_err
  );

  modport slave (
    output req, req_last, in_data, out_fifo_full,
    input  grant, xfer, out_data, out_valid, busy, wd_err
  );

endinterface

// File: rtl/spine_output_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
// The request vector is doubled so the wrap becomes a plain priority scan.
module rr_pick
  import spine_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int PW        = ptr_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] pick,
  output logic [PW-1:0]        pick_idx
);

  logic [2*NUM_PORTS-1:0] dbl;
  logic                   hit;

  assign dbl = {req, req};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    pick_idx = '0;
    hit      = 1'b0;
    // Scan downward so the lowest position inside the ptr window wins last.
    for (int j = 2*NUM_PORTS-1; j >= 0; j--) begin
      if (dbl[j] && (j >= int'(ptr)) && (j < int'(ptr) + NUM_PORTS)) begin
        hit      = 1'b1;
        pick_idx = PW'((j >= NUM_PORTS) ? j - NUM_PORTS : j);
      end
    end
    pick = hit ? (NUM_PORTS'(1) << pick_idx) : '0;
  end

endmodule

// File: rtl/spine_output_arbiter.sv
// Per-output wormhole arbiter: round-robin grant held for a whole packet.
// Define SPINE_ARB_WATCHDOG_EN to add the stalled-packet watchdog release.
module spine_output_arbiter
  import spine_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int DWIDTH    = 16,
  parameter int TIMEOUT   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  spine_output_arbiter_if.master   bus
);

  localparam int PW = ptr_w(NUM_PORTS);

  generate
    if (TIMEOUT < 2) begin : g_bad_timeout
      $error("spine_output_arbiter: TIMEOUT must be >= 2");
    end
  endgenerate

  arb_state_t           state;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        g_idx;
  logic [PW-1:0]        next_ptr;
  logic [NUM_PORTS-1:0] grant_q;
  logic [NUM_PORTS-1:0] pick;
  logic [PW-1:0]        pick_idx;
  logic                 req_g;
  logic                 last_g;
  logic [DWIDTH-1:0]    data_g;
  logic [DWIDTH-1:0]    out_data_q;
  logic                 out_valid_q;
  logic                 xfer_w;
  logic                 wd_fire;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PW        (PW)
  ) u_pick (
    .req      (bus.req),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // Select the granted input's request, last flag and flit.
  always_comb begin
    req_g  = 1'b0;
    last_g = 1'b0;
    data_g = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (g_idx == PW'(i)) begin
        req_g  = bus.req[i];
        last_g = bus.req_last[i];
        data_g = bus.in_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign xfer_w   = (state == LOCK) && req_g && !bus.out_fifo_full;
  assign next_ptr = (g_idx == PW'(NUM_PORTS-1)) ? '0 : g_idx + PW'(1);

`ifdef SPINE_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT+1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_err_q;

  // Counts consecutive LOCK cycles where the owner presents nothing; a full
  // output FIFO with req[g] high is back-pressure, not a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt   <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_err_q <= wd_fire;
      if (state == IDLE || req_g) wd_cnt <= '0;
      else                        wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign wd_fire    = (state == LOCK) && !req_g && (wd_cnt == WD_W'(TIMEOUT-1));
  assign bus.wd_err = wd_err_q;
`else
  assign wd_fire    = 1'b0;
  assign bus.wd_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      g_idx       <= '0;
      grant_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      out_valid_q <= xfer_w;
      if (xfer_w) out_data_q <= data_g;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            grant_q <= pick;
            g_idx   <= pick_idx;
            state   <= LOCK;
          end else begin
            grant_q <= '0;
          end
        end
        LOCK: begin
          if ((xfer_w && last_g) || wd_fire) begin
            grant_q <= '0;
            ptr     <= next_ptr;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.xfer      = xfer_w;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state == LOCK);

endmodule
